serial_subtractor_nb: RTL and testbench



---
 rtl/serial_subtractor_nb_pkg.sv | 14 +
 rtl/serial_subtractor_nb_full_subtractor.sv | 14 +
 rtl/serial_subtractor_nb.sv | 105 ++++++++++
 tb/tb_serial_subtractor_nb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_nb_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// bit-counter width helper.
package serial_subtractor_nb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Counter must hold 0..N, so a 1-bit operand still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_nb_full_subtractor.sv
// 1-bit combinational full subtractor: diff = a - b - bin, bout = borrow out.
// Also intended as the cell of a future ripple-borrow parallel subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nb.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor_nb
  import serial_subtractor_nb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int CW = cnt_width(N);

  logic [1:0]    state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          br;
  logic [CW-1:0] cnt;
  logic          a_msb;
  logic          b_msb;

  logic          d_bit;
  logic          br_next;
  logic          last_bit;
  logic [N-1:0]  diff_shift;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d_bit),
    .bout (br_next)
  );

  assign busy     = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);
  assign last_bit = (cnt == CW'(N - 1));

  // NOTE: every always_comb output gets a full default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    diff_shift        = diff >> 1;
    diff_shift[N-1]   = d_bit;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          diff <= diff_shift;
          if (last_bit) begin
            borrow <= br_next;
            ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          // Unused encoding 2'b11 behaves exactly like IDLE.
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            a_msb <= a[N-1];
            b_msb <= b[N-1];
            diff  <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Directed bench for serial_subtractor_nb at N = 16, 4 and 1: vector table,
// latency/busy checks, ignored mid-operation start and asynchronous reset.
module tb_serial_subtractor_nb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st16, bin16, busy16, done16, bo16, ov16;
  logic [15:0] a16, b16, d16;
  logic        st4, bin4, busy4, done4, bo4, ov4;
  logic [3:0]  a4, b4, d4;
  logic        st1, bin1, busy1, done1, bo1, ov1;
  logic [0:0]  a1, b1, d1;

  serial_subtractor_nb #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(d16), .borrow(bo16), .ovf(ov16));
  serial_subtractor_nb #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(d4), .borrow(bo4), .ovf(ov4));
  serial_subtractor_nb #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(d1), .borrow(bo1), .ovf(ov1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic st);
    case (w)
      16:      begin a16 = av;      b16 = bv;      bin16 = bi; st16 = st; end
      4:       begin a4  = av[3:0]; b4  = bv[3:0]; bin4  = bi; st4  = st; end
      default: begin a1  = av[0];   b1  = bv[0];   bin1  = bi; st1  = st; end
    endcase
  endtask

  function automatic logic sel_done(input int w);
    return (w == 16) ? done16 : (w == 4) ? done4 : done1;
  endfunction

  function automatic logic sel_busy(input int w);
    return (w == 16) ? busy16 : (w == 4) ? busy4 : busy1;
  endfunction

  function automatic logic [17:0] sel_res(input int w);
    case (w)
      16:      return {ov16, bo16, d16};
      4:       return {ov4, bo4, 12'h000, d4};
      default: return {ov1, bo1, 15'h0000, d1};
    endcase
  endfunction

  // Pulse start for one edge, then wait (bounded) for done at negedges.
  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, output int lat, output int busy_cnt);
    @(negedge clk);
    drive(w, av, bv, bi, 1'b1);
    @(negedge clk);
    drive(w, av, bv, bi, 1'b0);
    lat = 0;
    busy_cnt = 0;
    while (!sel_done(w) && lat < 40) begin
      if (sel_busy(w)) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_d;
    logic        exp_bo;
    logic        exp_ov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, busy_cnt, dones;
    logic [17:0] r;

    vecs = '{
      '{16, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0},
      '{16, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0},
      '{16, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1},
      '{16, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      '{16, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1},
      '{16, 16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{4,  16'h0003, 16'h0005, 1'b0, 16'h000E, 1'b1, 1'b0},
      '{4,  16'h0008, 16'h0001, 1'b0, 16'h0007, 1'b0, 1'b1},
      '{4,  16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0},
      '{4,  16'h0007, 16'h000F, 1'b0, 16'h0008, 1'b1, 1'b1},
      '{1,  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{1,  16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b1},
      '{1,  16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0},
      '{1,  16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0},
      '{1,  16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1},
      // Leaves borrow = 1 and ovf = 1 for the reset test below.
      '{16, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1}
    };

    drive(16, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(4,  16'h0, 16'h0, 1'b0, 1'b0);
    drive(1,  16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset16 outs", {busy16, done16, bo16, ov16, d16}, '0);
    check("reset4 outs",  {busy4, done4, bo4, ov4, d4}, '0);
    check("reset1 outs",  {busy1, done1, bo1, ov1, d1}, '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_cnt);
      r = sel_res(vecs[i].w);
      check($sformatf("v%0d latency", i), lat, vecs[i].w);
      check($sformatf("v%0d busy cycles", i), busy_cnt, vecs[i].w);
      check($sformatf("v%0d diff", i), r[15:0], vecs[i].exp_d);
      check($sformatf("v%0d borrow", i), r[16], vecs[i].exp_bo);
      check($sformatf("v%0d ovf", i), r[17], vecs[i].exp_ov);
      @(negedge clk);
      check($sformatf("v%0d done pulse width", i), {sel_done(vecs[i].w), sel_busy(vecs[i].w)}, 2'b00);
      check($sformatf("v%0d result held", i), sel_res(vecs[i].w), r);
    end

    // Asynchronous reset in the middle of an operation, after edge 8.
    @(negedge clk);
    drive(16, 16'h0005, 16'h0003, 1'b0, 1'b1);
    @(negedge clk);
    drive(16, 16'h0005, 16'h0003, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("pre-reset busy", busy16, 1'b1);
    rst = 1'b1;
    #1;
    check("async reset outs", {busy16, done16, bo16, ov16, d16}, '0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16, 16'h0010, 16'h0001, 1'b0, lat, busy_cnt);
    check("post-reset latency", lat, 16);
    check("post-reset diff", d16, 16'h000F);
    check("post-reset borrow/ovf", {bo16, ov16}, 2'b00);

    // Start pulsed mid-SHIFT with other operands must be ignored.
    @(negedge clk);
    drive(16, 16'h0005, 16'h0003, 1'b0, 1'b1);
    @(negedge clk);
    drive(16, 16'h0005, 16'h0003, 1'b0, 1'b0);
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 4) drive(16, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
      if (c == 6) drive(16, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
      if (done16) begin
        dones++;
        check("mid-start latency", c, 16);
        check("mid-start diff", d16, 16'h0002);
        check("mid-start borrow/ovf", {bo16, ov16}, 2'b00);
      end
      @(negedge clk);
    end
    check("mid-start done count", dones, 1);
    check("mid-start idle after", busy16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
